// File: rtl/enc_quad_frontend.sv
// enc_quad_frontend
//   Wheel encoder front end. The raw A/B quadrature channels are synchronised,
//   then each one is deglitched. The filtered pair is decoded into one-cycle
//   tick strobes with a direction flag and a signed position count. A free-running
//   gate counter produces a periodic measurement window, and a tick count is
//   reported for every completed window.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   enc_a      in   1       raw encoder channel A (asynchronous)
//   enc_b      in   1       raw encoder channel B (asynchronous)
//   err_clr    in   1       clears quad_err
//   tick       out  1       one-cycle strobe per valid quadrature transition
//   dir        out  1       1 = forward, 0 = reverse (last valid transition)
//   pos        out  POS_W   signed position, wraps modulo 2^POS_W
//   quad_err   out  1       sticky illegal-transition flag
//   window     out  1       one-cycle strobe at the end of each window
//   win_ticks  out  CNT_W   saturated tick count of the last completed window
//
// Decoder states
//   state    | meaning
//   UNPRIMED | filters track the synchroniser directly; no decode activity
//   RUN      | filtered pair decoded against its previous value

module enc_quad_frontend #(
    parameter int FILT_LEN    = 4,
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = 26,
    parameter int POS_W       = 16,
    parameter int CNT_W       = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             err_clr,
    output logic             tick,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             quad_err,
    output logic             window,
    output logic [CNT_W-1:0] win_ticks
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int PW = $clog2(FILT_LEN + 2);
    localparam logic [FW-1:0]     FILT_LAST  = FW'(FILT_LEN - 1);
    localparam logic [PW-1:0]     PRIME_LAST = PW'(FILT_LEN + 1);
    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic {UNPRIMED, RUN} state_e;

    // Channel pairs are packed as {A, B}.
    logic [1:0]          s1_q, s2_q;
    logic [1:0]          filt_q, filt_d;
    logic [1:0][FW-1:0]  fcnt_q, fcnt_d;
    logic [1:0]          prev_q, prev_d;
    state_e              state_q, state_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic                tick_q, tick_d;
    logic                dir_q, dir_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                err_q, err_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic                win_q, win_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    wt_q, wt_d;
    logic [CNT_W:0]      acc_sum;
    logic [CNT_W-1:0]    acc_sat;

    // Deglitch filters: a new level is accepted only after FILT_LEN
    // consecutive mismatching cycles. While unprimed they simply follow s2 so
    // the decoder starts from the real resting level of the encoder.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (state_q == UNPRIMED) begin
                filt_d[i] = s2_q[i];
            end else if (s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    // Decoder next state and outputs.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        prev_d  = filt_q;
        tick_d  = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        err_d   = err_q & ~err_clr;
        case (state_q)
            UNPRIMED: begin
                // prev tracks the same source as the filters so entry into
                // RUN never sees a phantom transition.
                prev_d = s2_q;
                if (pcnt_q == PRIME_LAST) begin
                    state_d = RUN;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            RUN: begin
                if (filt_q != prev_q) begin
                    case ({prev_q, filt_q})
                        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                            tick_d = 1'b1;
                            dir_d  = 1'b1;
                            pos_d  = pos_q + POS_W'(1);
                        end
                        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                            tick_d = 1'b1;
                            dir_d  = 1'b0;
                            pos_d  = pos_q - POS_W'(1);
                        end
                        // Both bits moved at once; a set wins over err_clr.
                        default: err_d = 1'b1;
                    endcase
                end
            end
            default: state_d = UNPRIMED;
        endcase
    end

    // Window gate and tick accumulation. tick_d is used so a tick that shows
    // up in the same cycle as the window strobe is reported with that window.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {{CNT_W{1'b0}}, tick_d};
        acc_sat = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
        win_d   = (gate_q == GATE_LAST);
        gate_d  = win_d ? '0 : gate_q + GATE_W'(1);
        wt_d    = wt_q;
        acc_d   = acc_sat;
        if (win_d) begin
            wt_d  = acc_sat;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            filt_q  <= '0;
            fcnt_q  <= '0;
            prev_q  <= '0;
            state_q <= UNPRIMED;
            pcnt_q  <= '0;
            tick_q  <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            err_q   <= 1'b0;
            gate_q  <= '0;
            win_q   <= 1'b0;
            acc_q   <= '0;
            wt_q    <= '0;
        end else begin
            s1_q    <= {enc_a, enc_b};
            s2_q    <= s1_q;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tick_q  <= tick_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            gate_q  <= gate_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
            wt_q    <= wt_d;
        end
    end

    assign tick      = tick_q;
    assign dir       = dir_q;
    assign pos       = pos_q;
    assign quad_err  = err_q;
    assign window    = win_q;
    assign win_ticks = wt_q;

endmodule
